// File: rtl/ram_bus_master.sv
// Bridge from the picorv32 native memory bus to a single-port synchronous word RAM.
// Decodes the RAM window, covers the registered read latency and answers out-of-range accesses.
module ram_bus_master #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_valid_i,
  input  logic                 mem_instr_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_wdata_i,
  input  logic [3:0]           mem_wstrb_i,
  output logic                 mem_ready_o,
  output logic [31:0]          mem_rdata_o,
  output logic                 mem_err_o,
  output logic                 ram_ce_o,
  output logic [3:0]           ram_wr_o,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic [31:0]          ram_d_o,
  input  logic [31:0]          ram_q_i
);

  localparam int unsigned TagLsb   = ADDR_BITS + 2;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDone} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic req_rd_q, req_rd_d;
  logic req_err_q, req_err_d;

  logic                 mem_ready_d, mem_err_d, ram_ce_d;
  logic [31:0]          mem_rdata_d, ram_d_d;
  logic [3:0]           ram_wr_d;
  logic [ADDR_BITS-1:0] ram_addr_d;

  logic in_range;
  assign in_range = (mem_addr_i[31:TagLsb] == BASE_ADDR[31:TagLsb]);

  // Fetch flag and byte offset carry no meaning for a word RAM.
  logic unused_inputs;
  assign unused_inputs = ^{mem_instr_i, mem_addr_i[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) state_d = in_range ? StIssue : StResp;
      end
      StIssue: begin
        if (WAIT_CYCLES > 0) begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end else begin
          state_d = StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_ready_d = 1'b0;
    mem_err_d   = 1'b0;
    mem_rdata_d = mem_rdata_o;
    ram_ce_d    = 1'b0;
    ram_wr_d    = 4'b0;
    ram_addr_d  = ram_addr_o;
    ram_d_d     = ram_d_o;
    req_rd_d    = req_rd_q;
    req_err_d   = req_err_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid_i) begin
          req_rd_d  = (mem_wstrb_i == 4'b0);
          req_err_d = !in_range;
          if (in_range) begin
            ram_ce_d   = 1'b1;
            ram_wr_d   = mem_wstrb_i;
            ram_addr_d = mem_addr_i[ADDR_BITS+1:2];
            ram_d_d    = mem_wdata_i;
          end
        end
      end
      StResp: begin
        mem_ready_d = 1'b1;
        mem_err_d   = req_err_q;
        mem_rdata_d = (req_rd_q && !req_err_q) ? ram_q_i : 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ready_o <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_rdata_o <= '0;
      ram_ce_o    <= 1'b0;
      ram_wr_o    <= '0;
      ram_addr_o  <= '0;
      ram_d_o     <= '0;
      req_rd_q    <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      mem_ready_o <= mem_ready_d;
      mem_err_o   <= mem_err_d;
      mem_rdata_o <= mem_rdata_d;
      ram_ce_o    <= ram_ce_d;
      ram_wr_o    <= ram_wr_d;
      ram_addr_o  <= ram_addr_d;
      ram_d_o     <= ram_d_d;
      req_rd_q    <= req_rd_d;
      req_err_q   <= req_err_d;
    end
  end

endmodule
